// File: rtl/enc_pkg.sv
// Shared sizing and helpers for the 8-to-3 pending priority encoder.
package enc_pkg;

  localparam int N = 8;
  localparam int W = $clog2(N);

  // Expand a line index into a single-bit mask over the request lines.
  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/prio_enc_8x3.sv
// Pure combinational priority encoder: highest set bit wins, plus any/multi flags.
module prio_enc_8x3
  import enc_pkg::*;
(
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] code_o,
  output logic         any_o,
  output logic         multi_o
);

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    code_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        code_o = W'(i);
      end
    end
  end

  assign any_o   = |vec_i;
  assign multi_o = |(vec_i & (vec_i - N'(1)));

endmodule

// File: rtl/encoder_8x3_pending.sv
// Registered 8-to-3 priority encoder with sticky request capture, ack-driven clear
// and a sticky overrun flag.
module encoder_8x3_pending
  import enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         multi,
  output logic [N-1:0] pending,
  output logic         overrun
);

  logic [N-1:0] pending_q, pending_d;
  logic         overrun_q, overrun_d;
  logic [N-1:0] clr_mask;
  logic [N-1:0] set_mask;

  prio_enc_8x3 u_prio (
    .vec_i   (pending_q),
    .code_o  (code),
    .any_o   (valid),
    .multi_o (multi)
  );

  // Set is OR-ed after the clear, so a re-request of the acked line keeps it pending.
  always_comb begin
    clr_mask  = (valid && ack) ? onehot(code) : '0;
    set_mask  = enable ? req : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    overrun_d = overrun_q | (|(set_mask & pending_q & ~clr_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_encoder_8x3_pending.sv
// Directed vector table plus randomized run against a behavioural model.
module tb_encoder_8x3_pending;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic       multi;
  logic [7:0] pending;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [7:0] e_pend;
    logic [2:0] e_code;
    logic       e_valid;
    logic       e_multi;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];

  encoder_8x3_pending dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .req     (req),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .multi   (multi),
    .pending (pending),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [7:0] rq, input logic a,
                     input logic [7:0] p, input logic [2:0] c, input logic v,
                     input logic m, input logic o);
    vec_t t;
    t.rst = r; t.en = e; t.req = rq; t.ack = a;
    t.e_pend = p; t.e_code = c; t.e_valid = v; t.e_multi = m; t.e_ovr = o;
    vecs.push_back(t);
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] rq, input logic a);
    rst = r; enable = e; req = rq; ack = a;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  logic [7:0] m_pend;
  logic       m_ovr;

  function automatic int top_index(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int count_bits(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [7:0] rq, input logic a);
    int hi;
    logic [7:0] nxt;
    if (r) begin
      m_pend = 8'h00;
      m_ovr  = 1'b0;
      return;
    end
    hi  = top_index(m_pend);
    nxt = m_pend;
    if (a && hi >= 0) nxt[hi] = 1'b0;
    if (e) begin
      for (int i = 0; i < 8; i++) begin
        if (rq[i]) begin
          if (m_pend[i] && !(a && i == hi)) m_ovr = 1'b1;
          nxt[i] = 1'b1;
        end
      end
    end
    m_pend = nxt;
  endtask

  initial begin
    int hi;
    rst = 1'b1; enable = 1'b0; req = 8'h00; ack = 1'b0;

    //   rst en  req    ack  pend   code  v  m  ovr
    add(1, 1, 8'hFF, 0, 8'h00, 3'd0, 0, 0, 0);
    add(1, 1, 8'hFF, 0, 8'h00, 3'd0, 0, 0, 0);
    add(0, 1, 8'h24, 0, 8'h24, 3'd5, 1, 1, 0);
    add(0, 0, 8'h00, 1, 8'h04, 3'd2, 1, 0, 0);
    add(0, 0, 8'h00, 1, 8'h00, 3'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 8'hFF, 0, 8'h00, 3'd0, 0, 0, 0);
    add(0, 0, 8'hFF, 1, 8'h00, 3'd0, 0, 0, 0);
    add(0, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0, 0);
    add(0, 1, 8'h20, 1, 8'h20, 3'd5, 1, 0, 0);
    add(0, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h20, 3'd5, 1, 0, 1);
    add(0, 1, 8'hD0, 0, 8'hF0, 3'd7, 1, 1, 1);
    add(0, 0, 8'h00, 1, 8'h70, 3'd6, 1, 1, 1);
    add(0, 0, 8'h00, 1, 8'h30, 3'd5, 1, 1, 1);
    add(0, 0, 8'h00, 1, 8'h10, 3'd4, 1, 0, 1);
    add(0, 0, 8'h00, 1, 8'h00, 3'd0, 0, 0, 1);
    add(0, 1, 8'hF0, 0, 8'hF0, 3'd7, 1, 1, 1);
    add(0, 0, 8'h00, 1, 8'h70, 3'd6, 1, 1, 1);
    add(1, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0, 0);
    add(0, 1, 8'h01, 0, 8'h01, 3'd0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 8'h00, 3'd0, 0, 0, 0);

    @(negedge clk);
    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].en, vecs[k].req, vecs[k].ack);
      $display("vec %0d: rst=%0b en=%0b req=%02h ack=%0b -> pend=%02h code=%0d v=%0b m=%0b ovr=%0b",
               k, vecs[k].rst, vecs[k].en, vecs[k].req, vecs[k].ack,
               pending, code, valid, multi, overrun);
      check($sformatf("vec%0d.pending", k), pending, vecs[k].e_pend);
      check($sformatf("vec%0d.code", k),    code,    vecs[k].e_code);
      check($sformatf("vec%0d.valid", k),   valid,   vecs[k].e_valid);
      check($sformatf("vec%0d.multi", k),   multi,   vecs[k].e_multi);
      check($sformatf("vec%0d.overrun", k), overrun, vecs[k].e_ovr);
    end

    // Randomized run: start from a clean reset so the model is in step.
    m_pend = 8'h00; m_ovr = 1'b0;
    step(1, 0, 8'h00, 0);
    for (int n = 0; n < 400; n++) begin
      logic       r, e, a;
      logic [7:0] rq;
      r  = ($urandom_range(0, 40) == 0);
      e  = $urandom_range(0, 1);
      rq = 8'($urandom) & 8'($urandom) & 8'($urandom);
      a  = ($urandom_range(0, 2) != 0);
      step(r, e, rq, a);
      model_step(r, e, rq, a);
      hi = top_index(m_pend);
      $display("rnd %0d: rst=%0b en=%0b req=%02h ack=%0b -> pend=%02h code=%0d ovr=%0b",
               n, r, e, rq, a, pending, code, overrun);
      check("rnd.pending", pending, m_pend);
      check("rnd.code",    code,    (hi < 0) ? 0 : hi);
      check("rnd.valid",   valid,   (hi >= 0) ? 1 : 0);
      check("rnd.multi",   multi,   (count_bits(m_pend) > 1) ? 1 : 0);
      check("rnd.overrun", overrun, m_ovr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
